// File: rtl/flash_qspi_arbiter_if.sv
// Request/response and flash pin bundle for the quad-SPI read arbiter.
// The slave side is the controller; the master side is everything around it.
interface flash_qspi_arbiter_if;
    logic        req0_valid;
    logic [23:0] req0_addr;
    logic        req0_ready;
    logic        req1_valid;
    logic [23:0] req1_addr;
    logic        req1_ready;
    logic [31:0] rdata;
    logic        busy;
    logic [1:0]  flash_clk_ddr;
    logic        flash_csn;
    logic [3:0]  flash_in_en;
    logic [3:0]  flash_in;
    logic [3:0]  flash_out;

    // Requests: valid/addr are held by the requester until its ready pulses.
    // ready is a single-cycle completion pulse with rdata valid in that cycle.
    modport slave (
        input  req0_valid, req0_addr, req1_valid, req1_addr, flash_out,
        output req0_ready, req1_ready, rdata, busy,
               flash_clk_ddr, flash_csn, flash_in_en, flash_in
    );

    modport master (
        output req0_valid, req0_addr, req1_valid, req1_addr, flash_out,
        input  req0_ready, req1_ready, rdata, busy,
               flash_clk_ddr, flash_csn, flash_in_en, flash_in
    );
endinterface

// File: rtl/flash_qspi_arbiter.sv
// Two-port round-robin arbiter issuing one 0xEB quad fast-read per grant and
// returning a little-endian 32-bit word; all pin outputs are registered.
module flash_qspi_arbiter #(
    parameter int DUMMY_CYCLES    = 4,
    parameter int INPUT_LATENCY   = 2,
    parameter int CSN_HIGH_CYCLES = 2
) (
    input  logic                clk_2x,
    input  logic                reset,
    flash_qspi_arbiter_if.slave bus,
    output logic [2:0]          state_dbg_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMD     = 3'd1,
        S_ADDR    = 3'd2,
        S_MODE    = 3'd3,
        S_DUMMY   = 3'd4,
        S_DATA    = 3'd5,
        S_DRAIN   = 3'd6,
        S_CS_HIGH = 3'd7
    } state_e;

    localparam logic [7:0] CMD_QUAD_READ = 8'hEB;
    localparam logic [7:0] DUMMY_LAST    = 8'(DUMMY_CYCLES - 1);
    localparam logic [7:0] DRAIN_LAST    = 8'(INPUT_LATENCY - 1);
    localparam logic [7:0] CSH_LAST      = 8'(CSN_HIGH_CYCLES - 1);

    state_e                   state_q, state_d;
    logic [7:0]               cnt_q, cnt_d;
    logic [23:0]              addr_q, addr_d;
    logic                     port_q, port_d;
    logic                     last_q, last_d;
    logic [INPUT_LATENCY-1:0] pipe_q, pipe_d;
    logic [INPUT_LATENCY:0]   pipe_ext;
    logic [31:0]              sr_q, sr_d;
    logic [31:0]              rdata_q, rdata_d;
    logic                     ready0_q, ready0_d;
    logic                     ready1_q, ready1_d;
    logic                     busy_q, busy_d;
    logic                     csn_q, csn_d;
    logic [1:0]               ddr_q, ddr_d;
    logic [3:0]               in_en_q, in_en_d;
    logic [3:0]               in_q, in_d;
    logic                     grant;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 8'd1;
        addr_d   = addr_q;
        port_d   = port_q;
        last_d   = last_q;
        rdata_d  = rdata_q;
        ready0_d = 1'b0;
        ready1_d = 1'b0;
        grant    = 1'b0;

        // Each DATA pulse marks a slot that reaches the capture point
        // INPUT_LATENCY cycles later, when its nibble sits on flash_out.
        pipe_ext = {pipe_q, (state_q == S_DATA)};
        pipe_d   = pipe_ext[INPUT_LATENCY-1:0];
        sr_d     = pipe_q[INPUT_LATENCY-1] ? {sr_q[27:0], bus.flash_out} : sr_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = 8'd0;
                if (bus.req0_valid || bus.req1_valid) begin
                    grant   = (bus.req0_valid && bus.req1_valid) ? ~last_q : bus.req1_valid;
                    state_d = S_CMD;
                    port_d  = grant;
                    last_d  = grant;
                    addr_d  = grant ? bus.req1_addr : bus.req0_addr;
                end
            end
            S_CMD:     if (cnt_q == 8'd7)      begin state_d = S_ADDR;  cnt_d = 8'd0; end
            S_ADDR:    if (cnt_q == 8'd5)      begin state_d = S_MODE;  cnt_d = 8'd0; end
            S_MODE:    if (cnt_q == 8'd1)      begin state_d = S_DUMMY; cnt_d = 8'd0; end
            S_DUMMY:   if (cnt_q == DUMMY_LAST) begin state_d = S_DATA; cnt_d = 8'd0; end
            S_DATA:    if (cnt_q == 8'd7)      begin state_d = S_DRAIN; cnt_d = 8'd0; end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d  = S_CS_HIGH;
                    cnt_d    = 8'd0;
                    // First nibble of each byte is its high half; byte 0 goes low.
                    rdata_d  = {sr_d[7:0], sr_d[15:8], sr_d[23:16], sr_d[31:24]};
                    ready0_d = ~port_q;
                    ready1_d = port_q;
                end
            end
            S_CS_HIGH: if (cnt_q == CSH_LAST)  begin state_d = S_IDLE;  cnt_d = 8'd0; end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        // Pin values are derived from the upcoming state so they are registered.
        csn_d   = 1'b1;
        ddr_d   = 2'b00;
        in_en_d = 4'b0000;
        in_d    = 4'b0000;
        case (state_d)
            S_CMD: begin
                csn_d   = 1'b0;
                ddr_d   = 2'b10;
                in_en_d = 4'b1101;
                in_d    = {3'b110, CMD_QUAD_READ[3'd7 - cnt_d[2:0]]};
            end
            S_ADDR: begin
                csn_d   = 1'b0;
                ddr_d   = 2'b10;
                in_en_d = 4'b1111;
                case (cnt_d[2:0])
                    3'd0:    in_d = addr_d[23:20];
                    3'd1:    in_d = addr_d[19:16];
                    3'd2:    in_d = addr_d[15:12];
                    3'd3:    in_d = addr_d[11:8];
                    3'd4:    in_d = addr_d[7:4];
                    default: in_d = addr_d[3:0];
                endcase
            end
            S_MODE: begin
                csn_d   = 1'b0;
                ddr_d   = 2'b10;
                in_en_d = 4'b1111;
            end
            S_DUMMY, S_DATA: begin
                csn_d = 1'b0;
                ddr_d = 2'b10;
            end
            S_DRAIN: csn_d = 1'b0;
            default: ;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_2x) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 8'd0;
            addr_q   <= 24'd0;
            port_q   <= 1'b0;
            last_q   <= 1'b1;
            pipe_q   <= '0;
            sr_q     <= 32'd0;
            rdata_q  <= 32'd0;
            ready0_q <= 1'b0;
            ready1_q <= 1'b0;
            busy_q   <= 1'b0;
            csn_q    <= 1'b1;
            ddr_q    <= 2'b00;
            in_en_q  <= 4'b0000;
            in_q     <= 4'b0000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            port_q   <= port_d;
            last_q   <= last_d;
            pipe_q   <= pipe_d;
            sr_q     <= sr_d;
            rdata_q  <= rdata_d;
            ready0_q <= ready0_d;
            ready1_q <= ready1_d;
            busy_q   <= busy_d;
            csn_q    <= csn_d;
            ddr_q    <= ddr_d;
            in_en_q  <= in_en_d;
            in_q     <= in_d;
        end
    end

    assign bus.req0_ready    = ready0_q;
    assign bus.req1_ready    = ready1_q;
    assign bus.rdata         = rdata_q;
    assign bus.busy          = busy_q;
    assign bus.flash_clk_ddr = ddr_q;
    assign bus.flash_csn     = csn_q;
    assign bus.flash_in_en   = in_en_q;
    assign bus.flash_in      = in_q;
    assign state_dbg_o       = state_q;

endmodule

// File: tb/tb_flash_qspi_arbiter.sv
// Bench for flash_qspi_arbiter: default and long-latency instances share one
// stimulus stream; a pin-level flash model feeds each and a scoreboard checks completions.
module tb_flash_qspi_arbiter;

    localparam int CSH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic [1:0]  issue_mask = 2'b00;
    logic [23:0] issue_a0 = 24'd0;
    logic [23:0] issue_a1 = 24'd0;
    int          issue_mode = 0;   // 0 normal, 1 drop valid at T+10, 2 reset at T+20
    int          issue_cyc = 0;
    int          done_cnt = 0;
    event        issue_ev;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Flash contents as a simple function of byte address.
    function automatic logic [7:0] fbyte(input logic [23:0] a);
        return 8'((a[7:0] + 8'd1) * 8'h11) ^ a[15:8] ^ a[23:16] ^ 8'h10;
    endfunction

    function automatic logic [31:0] fword(input logic [23:0] a);
        return {fbyte(a + 24'd3), fbyte(a + 24'd2), fbyte(a + 24'd1), fbyte(a)};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int D   = (g == 0) ? 4 : 6;
        localparam int L   = (g == 0) ? 2 : 3;
        localparam int LAT = 24 + D + L;   // busy rise to ready pulse

        flash_qspi_arbiter_if bus ();
        logic [2:0]  state_dbg;
        logic [64:0] exp_q[$];            // {port, rdata, start cycle}
        logic        last_grant;
        logic [3:0]  ring[64];

        flash_qspi_arbiter #(
            .DUMMY_CYCLES(D),
            .INPUT_LATENCY(L),
            .CSN_HIGH_CYCLES(CSH)
        ) dut (
            .clk_2x(clk),
            .reset(rst),
            .bus(bus),
            .state_dbg_o(state_dbg)
        );

        initial begin : flash_drive
            logic [5:0] idx;
            bus.flash_out = 4'd0;
            forever begin
                @(posedge clk);
                #1;
                idx = 6'(cyc);
                bus.flash_out = ring[idx];
            end
        end

        initial begin : flash_model
            int         p;
            int         bad;
            int         k;
            logic [7:0] cmd;
            logic [23:0] fa;
            logic [7:0] b;
            logic [3:0] nib;
            logic       csn_prev;
            logic       rst_prev;
            logic [5:0] widx;
            for (int i = 0; i < 64; i++) ring[i] = 4'd0;
            p = 0; bad = 0; cmd = 8'd0; fa = 24'd0; csn_prev = 1'b1; rst_prev = 1'b0;
            forever begin
                @(negedge clk);
                nib = 4'($urandom);
                if (rst || rst_prev) begin
                    p = 0; bad = 0; cmd = 8'd0; fa = 24'd0;
                end else begin
                    if (bus.flash_clk_ddr == 2'b10) begin
                        if (bus.flash_csn) bad++;
                        else if (p < 8) begin
                            cmd = {cmd[6:0], bus.flash_in[0]};
                            if (bus.flash_in_en != 4'b1101 || bus.flash_in[3:1] != 3'b110) bad++;
                        end else if (p < 14) begin
                            fa = {fa[19:0], bus.flash_in};
                            if (bus.flash_in_en != 4'b1111) bad++;
                        end else if (p < 16) begin
                            if (bus.flash_in_en != 4'b1111 || bus.flash_in != 4'd0) bad++;
                        end else if (p < 16 + D) begin
                            if (bus.flash_in_en != 4'b0000) bad++;
                        end else if (p < 24 + D) begin
                            k   = p - 16 - D;
                            b   = fbyte(fa + 24'(k / 2));
                            nib = (k % 2 == 0) ? b[7:4] : b[3:0];
                            if (bus.flash_in_en != 4'b0000) bad++;
                        end else bad++;
                        p++;
                    end else if (bus.flash_clk_ddr != 2'b00) bad++;
                    if (!csn_prev && bus.flash_csn) begin
                        checks++;
                        if (cmd != 8'hEB || p != 24 + D || bad != 0) begin
                            errors++;
                            $display("FAIL inst%0d flash_txn: cmd=%02h pulses=%0d bad=%0d, required cmd=eb pulses=%0d bad=0",
                                     g, cmd, p, bad, 24 + D);
                        end
                        p = 0; bad = 0;
                    end
                end
                widx = 6'(cyc + L);
                ring[widx] = nib;
                csn_prev = bus.flash_csn;
                rst_prev = rst;
            end
        end

        initial begin : agent
            int         s1;
            int         n;
            logic       first;
            logic [1:0] pend;
            bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
            bus.req0_addr  = 24'd0; bus.req1_addr = 24'd0;
            last_grant = 1'b1;
            forever begin
                @(issue_ev);
                s1 = issue_cyc + 1;
                if (issue_mode != 2) begin
                    if (issue_mask == 2'b11) begin
                        first = ~last_grant;
                        exp_q.push_back({first, fword(first ? issue_a1 : issue_a0), 32'(s1)});
                        exp_q.push_back({~first, fword(first ? issue_a0 : issue_a1), 32'(s1 + LAT + CSH + 1)});
                        last_grant = ~first;
                    end else begin
                        first = issue_mask[1];
                        exp_q.push_back({first, fword(first ? issue_a1 : issue_a0), 32'(s1)});
                        last_grant = first;
                    end
                end
                bus.req0_addr  = issue_a0;
                bus.req1_addr  = issue_a1;
                bus.req0_valid = issue_mask[0];
                bus.req1_valid = issue_mask[1];
                pend = issue_mask;
                n = 0;
                while (pend != 2'b00 && n < 400) begin
                    @(negedge clk);
                    n++;
                    if (bus.req0_ready) begin pend[0] = 1'b0; bus.req0_valid = 1'b0; end
                    if (bus.req1_ready) begin pend[1] = 1'b0; bus.req1_valid = 1'b0; end
                    if (issue_mode == 1 && cyc == issue_cyc + 10) begin
                        bus.req0_valid = 1'b0;
                        bus.req0_addr  = 24'hFFFFFF;
                    end
                    if (issue_mode == 2 && rst) begin
                        pend = 2'b00;
                        bus.req0_valid = 1'b0;
                        bus.req1_valid = 1'b0;
                        last_grant = 1'b1;
                    end
                end
                checks++;
                if (pend != 2'b00) begin
                    errors++;
                    $display("FAIL inst%0d ready_timeout: pending=%b, required pending=00", g, pend);
                    bus.req0_valid = 1'b0;
                    bus.req1_valid = 1'b0;
                end
                done_cnt++;
            end
        end

        initial begin : monitor
            logic        busy_prev;
            logic        rst_prev;
            int          start_seen;
            int          ready_cyc;
            logic [64:0] e;
            busy_prev = 1'b0; rst_prev = 1'b0; start_seen = 0; ready_cyc = 0;
            forever begin
                @(negedge clk);
                if (rst_prev) begin
                    checks++;
                    if (bus.flash_csn !== 1'b1 || bus.flash_clk_ddr !== 2'b00 || bus.flash_in_en !== 4'd0 ||
                        bus.flash_in !== 4'd0 || bus.rdata !== 32'd0 || bus.busy !== 1'b0 ||
                        bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 || state_dbg !== 3'd0) begin
                        errors++;
                        $display("FAIL inst%0d reset_vals: csn=%b ddr=%b en=%b in=%h rdata=%h busy=%b rdy=%b%b st=%0d, required csn=1 rest 0",
                                 g, bus.flash_csn, bus.flash_clk_ddr, bus.flash_in_en, bus.flash_in, bus.rdata,
                                 bus.busy, bus.req1_ready, bus.req0_ready, state_dbg);
                    end
                end else begin
                    if (bus.busy && !busy_prev) start_seen = cyc;
                    if (!bus.busy && busy_prev) begin
                        checks++;
                        if (cyc - ready_cyc != CSH) begin
                            errors++;
                            $display("FAIL inst%0d busy_tail: cycles after ready=%0d, required %0d", g, cyc - ready_cyc, CSH);
                        end
                    end
                    if (bus.req0_ready && bus.req1_ready) begin
                        checks++;
                        errors++;
                        $display("FAIL inst%0d both_ready: rdy=11, required at most one", g);
                    end else if (bus.req0_ready || bus.req1_ready) begin
                        ready_cyc = cyc;
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL inst%0d spurious_ready: port=%0d, required no pulse", g, bus.req1_ready);
                        end else begin
                            e = exp_q.pop_front();
                            if (bus.req1_ready != e[64] || bus.rdata != e[63:32] || start_seen != int'(e[31:0]) ||
                                cyc - start_seen != LAT || bus.flash_csn != 1'b1) begin
                                errors++;
                                $display("FAIL inst%0d completion: port=%0d rdata=%08h start=%0d lat=%0d csn=%b, required port=%0d rdata=%08h start=%0d lat=%0d csn=1",
                                         g, bus.req1_ready, bus.rdata, start_seen, cyc - start_seen, bus.flash_csn,
                                         e[64], e[63:32], int'(e[31:0]), LAT);
                            end
                        end
                    end
                end
                busy_prev = bus.busy;
                rst_prev  = rst;
            end
        end
    end

    task automatic do_issue(input logic [1:0] mask, input logic [23:0] a0, input logic [23:0] a1, input int mode);
        int n;
        @(posedge clk);
        #1;
        issue_mask = mask;
        issue_a0   = a0;
        issue_a1   = a1;
        issue_mode = mode;
        issue_cyc  = cyc;
        done_cnt   = 0;
        -> issue_ev;
        if (mode == 2) begin
            repeat (20) @(posedge clk);
            #1 rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
        end
        n = 0;
        while (done_cnt < 2 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (done_cnt < 2) begin
            errors++;
            $display("FAIL driver_timeout: agents done=%0d, required 2", done_cnt);
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);

        do_issue(2'b11, 24'h100000, 24'h200010, 0);   // first tie after reset: port 0 first
        do_issue(2'b11, 24'h345678, 24'h00ABCD, 0);
        do_issue(2'b11, 24'h000001, 24'hFFFFFD, 0);
        do_issue(2'b01, 24'h100000, 24'h000000, 0);   // 11 22 33 44
        do_issue(2'b10, 24'h000000, 24'h000003, 0);   // port 1 alone, unaligned
        do_issue(2'b01, 24'h123456, 24'h000000, 2);   // reset during DUMMY
        do_issue(2'b01, 24'h000FFE, 24'h000000, 0);
        do_issue(2'b11, 24'h0F0F0F, 24'h707070, 0);   // tie right after reset
        do_issue(2'b01, 24'h123456, 24'h000000, 1);   // valid dropped, addr changed
        do_issue(2'b10, 24'h000000, 24'hFFFFFE, 0);   // wraps at top of flash

        for (int i = 0; i < 20; i++) begin
            do_issue(2'($urandom_range(1, 3)), 24'($urandom), 24'($urandom), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
